fir_mac_seq: RTL and testbench
==============================

Name: fir_mac_seq

Overview:
- Sequencer and multiply-accumulate stage placed directly downstream of the addressable delay line (asr) in the FIR datapath.
- Accepts one input sample per handshake and drives it into the delay line's data input.
- Sweeps the delay-line tap address 0..N_TAPS-1, multiplies each returned tap by the matching coefficient, and accumulates the products.
- Shifts the delay line once, then emits one scaled, saturated filter output.

Parameters:
- WIDTH_DATA, 8, signed sample width (delay-line data width).
- WIDTH_COEF, 8, signed coefficient width (Q1.7 at default).
- N_TAPS, 16, number of taps; power of two, ≥2.
- WIDTH_MAC_OUT, 8, signed output width.
- OUT_SHIFT, 7, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- clr  in  1  synchronous active-high reset.
- in_valid  in  1  input sample strobe.
- in_ready  out  1  block can accept a sample; high only in IDLE.
- in_data  in  WIDTH_DATA  signed input sample.
- asr_d  out  WIDTH_DATA  to delay-line d; registered copy of the accepted sample.
- asr_en  out  1  to delay-line en; single-cycle shift pulse.
- asr_clr  out  1  to delay-line clr; equals clr combinationally.
- asr_add  out  $clog2(N_TAPS)  to delay-line add; registered tap index.
- asr_q  in  WIDTH_DATA  from delay-line q; combinational tap value for asr_add.
- coef_add  out  $clog2(N_TAPS)  coefficient ROM address; equals asr_add.
- coef  in  WIDTH_COEF  signed coefficient; combinational from coef_add.
- out_valid  out  1  one-cycle result strobe.
- out_data  out  WIDTH_MAC_OUT  signed filter output.

Behaviour:
- Reset (clr=1 at an edge), all outputs and state:
  - state=IDLE, tap=0, acc=0, prod=0, prod_valid=0.
  - asr_d=0, asr_en=0, out_valid=0, out_data=0; in_ready=1 after the edge.
  - asr_clr=1 while clr is high, which clears the delay line.
- Reset mid-operation: aborts the computation from any state. No out_valid and no asr_en are produced for the aborted sample, and the history is cleared.
- Accumulator width: WIDTH_DATA+WIDTH_COEF+$clog2(N_TAPS), signed. Products are a full-width signed multiply.
- States and transitions:
  - IDLE:
    - in_ready=1.
    - On in_valid: asr_d<=in_data, tap<=0, acc<=0, prod_valid<=0, go to MAC.
    - in_valid while not in IDLE is ignored; no queueing.
  - MAC (N_TAPS cycles):
    - asr_add=tap.
    - prod<=asr_q*coef, prod_valid<=1.
    - If prod_valid: acc<=acc+prod.
    - tap<=tap+1. When tap==N_TAPS-1, go to ACC (tap wraps to 0).
  - ACC (1 cycle): acc<=acc+prod, go to SHIFT.
  - SHIFT (1 cycle):
    - asr_en=1, so the delay line shifts asr_d in at the edge ending this cycle.
    - out_data<=sat(acc>>>OUT_SHIFT), out_valid<=1, go to IDLE.
- Tap semantics:
  - add=0 returns asr_d, which is x[n].
  - add=k returns x[n-k].
  - Result: y[n] = Σ coef[k]·x[n-k] over k=0..N_TAPS-1.
- Scaling: arithmetic right shift, truncation toward −∞ (no rounding).
- Saturation:
  - Shifted value > 2^(WIDTH_MAC_OUT-1)-1 clamps to the maximum.
  - Shifted value < −2^(WIDTH_MAC_OUT-1) clamps to the minimum.
- Timing, for acceptance at edge E0:
  - in_ready is low for N_TAPS+2 cycles.
  - asr_en is high during cycle N_TAPS+2.
  - out_valid is high for exactly one cycle, cycle N_TAPS+3 (19 at default).
- Back-to-back operation: in_valid may be accepted in the same cycle out_valid is high. Minimum sample period is N_TAPS+3 cycles.
- out_data holds its value until the next result or reset.
- asr_add is constant outside MAC.

Test Plan:
- Impulse: coef[k]=2k, samples 64,0,0,… (20 samples) -> out_data sequence 0,1,2,…,15, then 0,0,0,0.
- Timing: single accepted sample -> in_ready low exactly 18 cycles; asr_en high only in cycle 18; out_valid high only in cycle 19; asr_add steps 0..15 in cycles 1..16.
- Saturation: all coef=127, 16+ samples of 127 -> out_data=127 once the line is full. Same with samples −128 -> out_data=−128.
- Truncation: coef[0]=1, others 0, sample −1 after reset -> out_data=−1. Sample +1 -> out_data=0.
- Ignore busy: pulse in_valid with in_data=55 in cycle 5 of a computation -> not captured, no extra out_valid, history unchanged.
- Mid-op reset: clr high during MAC with tap=5 -> no out_valid, asr_clr=1 that cycle, in_ready=1 next cycle. A following impulse test reproduces the clean-start sequence exactly.

Source files
------------

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequencer and multiply-accumulate stage for the FIR datapath.
// Sits directly after the addressable delay line (asr). Each accepted sample
// is presented on asr_d. The block then sweeps the tap address, multiplies
// every returned tap by its coefficient and accumulates the products. Finally
// it shifts the delay line once and emits one scaled, saturated output.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset (also drives asr_clr)
//   in_valid   input sample strobe; taken only while in_ready is high
//   in_ready   high in IDLE only
//   in_data    signed input sample
//   asr_d      registered copy of the accepted sample, to the delay line
//   asr_en     single-cycle delay-line shift pulse
//   asr_clr    delay-line clear, equal to clr
//   asr_add    registered tap address
//   asr_q      combinational tap value at asr_add
//   coef_add   coefficient ROM address (same as asr_add)
//   coef       signed coefficient at coef_add
//   out_valid  one-cycle result strobe
//   out_data   signed filter output, held until the next result
//
// state  | meaning
// IDLE   | waiting for a sample, in_ready high
// MAC    | one tap per cycle: multiply, accumulate previous product
// ACC    | fold in the final product
// SHIFT  | pulse asr_en, register the scaled/saturated result
module fir_mac_seq #(
  parameter int WIDTH_DATA    = 8,
  parameter int WIDTH_COEF    = 8,
  parameter int N_TAPS        = 16,
  parameter int WIDTH_MAC_OUT = 8,
  parameter int OUT_SHIFT     = 7
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [WIDTH_DATA-1:0]      in_data,
  output logic signed [WIDTH_DATA-1:0]      asr_d,
  output logic                              asr_en,
  output logic                              asr_clr,
  output logic [$clog2(N_TAPS)-1:0]         asr_add,
  input  logic signed [WIDTH_DATA-1:0]      asr_q,
  output logic [$clog2(N_TAPS)-1:0]         coef_add,
  input  logic signed [WIDTH_COEF-1:0]      coef,
  output logic                              out_valid,
  output logic signed [WIDTH_MAC_OUT-1:0]   out_data
);

  localparam int ADD_W  = $clog2(N_TAPS);
  localparam int PROD_W = WIDTH_DATA + WIDTH_COEF;
  localparam int ACC_W  = PROD_W + ADD_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_ACC   = 2'd2;
  localparam logic [1:0] S_SHIFT = 2'd3;

  localparam logic [ADD_W-1:0] TAP_LAST = ADD_W'(N_TAPS - 1);

  // Clamp limits expressed at accumulator width; ~max is -(max+1) = min.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (WIDTH_MAC_OUT - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]                       state;
  logic [ADD_W-1:0]                 tap;
  logic signed [ACC_W-1:0]          acc;
  logic signed [PROD_W-1:0]         prod;
  logic                             prod_valid;
  logic signed [ACC_W-1:0]          acc_shifted;
  logic signed [WIDTH_MAC_OUT-1:0]  acc_sat;

  assign in_ready = (state == S_IDLE);
  assign asr_clr  = clr;
  // Gated by clr so an abort during SHIFT never shifts the line.
  assign asr_en   = (state == S_SHIFT) && !clr;
  assign asr_add  = tap;
  assign coef_add = tap;

  always_comb begin
    acc_shifted = acc >>> OUT_SHIFT;
    acc_sat     = acc_shifted[WIDTH_MAC_OUT-1:0];
    if (acc_shifted > SAT_MAX)
      acc_sat = SAT_MAX[WIDTH_MAC_OUT-1:0];
    else if (acc_shifted < SAT_MIN)
      acc_sat = SAT_MIN[WIDTH_MAC_OUT-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      tap        <= '0;
      acc        <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      asr_d      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            asr_d      <= in_data;
            tap        <= '0;
            acc        <= '0;
            prod_valid <= 1'b0;
            state      <= S_MAC;
          end
        end
        S_MAC: begin
          // Product is pipelined one cycle; the last one is folded in ACC.
          prod       <= PROD_W'(asr_q) * PROD_W'(coef);
          prod_valid <= 1'b1;
          if (prod_valid)
            acc <= acc + ACC_W'(prod);
          tap <= tap + 1'b1;
          if (tap == TAP_LAST)
            state <= S_ACC;
        end
        S_ACC: begin
          acc   <= acc + ACC_W'(prod);
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          out_data  <= acc_sat;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
module tb_fir_mac_seq;

  localparam int N = 16;

  logic              clk = 1'b0;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic signed [7:0] asr_d;
  logic              asr_en;
  logic              asr_clr;
  logic [3:0]        asr_add;
  logic signed [7:0] asr_q;
  logic [3:0]        coef_add;
  logic signed [7:0] coef;
  logic              out_valid;
  logic signed [7:0] out_data;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int exp_q[$];

  logic signed [7:0] coefs [N];
  logic signed [7:0] line  [N-1];

  always #5 clk = ~clk;

  fir_mac_seq dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .asr_d(asr_d), .asr_en(asr_en), .asr_clr(asr_clr),
    .asr_add(asr_add), .asr_q(asr_q), .coef_add(coef_add), .coef(coef),
    .out_valid(out_valid), .out_data(out_data)
  );

  // Delay line: address 0 is the live input, address k is k samples older.
  always_ff @(posedge clk) begin
    if (asr_clr) begin
      for (int i = 0; i < N-1; i++) line[i] <= '0;
    end else if (asr_en) begin
      line[0] <= asr_d;
      for (int i = 1; i < N-1; i++) line[i] <= line[i-1];
    end
  end

  always_comb begin
    asr_q = asr_d;
    if (asr_add != 4'd0) asr_q = line[asr_add - 4'd1];
    coef = coefs[coef_add];
  end

  task automatic check(input string name, input int act, input int expv);
    check_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!clr && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("out_data", int'(out_data), e);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("asr_clr_in_reset", int'(asr_clr), 1);
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic send(input logic signed [7:0] d, input int expv, input bit push, input bit busy);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      if (push) exp_q.push_back(expv);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (busy) begin
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = 8'sd55;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = '0;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_impulse_coefs();
    for (int k = 0; k < N; k++) coefs[k] = 8'(2 * k);
  endtask

  task automatic impulse_run(input bit with_busy);
    send(8'sd64, 0, 1'b1, 1'b0);
    for (int k = 1; k < 20; k++)
      send(8'sd0, (k < N) ? k : 0, 1'b1, with_busy && (k == 3));
    drain();
  endtask

  initial begin
    clr = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    for (int k = 0; k < N; k++) coefs[k] = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_asr_d", int'(asr_d), 0);
    check("rst_asr_en", int'(asr_en), 0);
    check("rst_asr_add", int'(asr_add), 0);
    check("rst_asr_clr", int'(asr_clr), 0);

    // Impulse, with an in_valid pulse that must be ignored while busy
    set_impulse_coefs();
    impulse_run(1'b1);

    // Timing of a single sample
    do_reset();
    send(8'sd64, 0, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      check($sformatf("in_ready_c%0d", cyc), int'(in_ready), (cyc >= 19) ? 1 : 0);
      check($sformatf("asr_en_c%0d", cyc), int'(asr_en), (cyc == 18) ? 1 : 0);
      check($sformatf("out_valid_c%0d", cyc), int'(out_valid), (cyc == 19) ? 1 : 0);
      check($sformatf("asr_add_c%0d", cyc), int'(asr_add), (cyc <= 16) ? cyc - 1 : 0);
    end
    drain();

    // Truncation toward minus infinity
    do_reset();
    for (int k = 0; k < N; k++) coefs[k] = '0;
    coefs[0] = 8'sd1;
    send(-8'sd1, -1, 1'b1, 1'b0);
    send(8'sd1, 0, 1'b1, 1'b0);
    drain();

    // Positive and negative saturation
    do_reset();
    for (int k = 0; k < N; k++) coefs[k] = 8'sd127;
    for (int k = 0; k < 17; k++) send(8'sd127, (k == 0) ? 126 : 127, 1'b1, 1'b0);
    drain();
    check("sat_hold_max", int'(out_data), 127);
    do_reset();
    for (int k = 0; k < 17; k++) send(-8'sd128, (k == 0) ? -127 : -128, 1'b1, 1'b0);
    drain();
    check("sat_hold_min", int'(out_data), -128);

    // Mid-operation reset at tap 5
    do_reset();
    set_impulse_coefs();
    send(8'sd64, 0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("midop_tap", int'(asr_add), 5);
    clr = 1'b1;
    @(negedge clk);
    check("midop_asr_clr", int'(asr_clr), 1);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("midop_in_ready", int'(in_ready), 1);
    begin
      int nv = 0;
      int ne = 0;
      for (int c = 0; c < 25; c++) begin
        if (out_valid) nv++;
        if (asr_en) ne++;
        @(negedge clk);
      end
      check("midop_no_out_valid", nv, 0);
      check("midop_no_asr_en", ne, 0);
    end
    impulse_run(1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
